// File: rtl/imm_gen_pipe.sv
// RISC-V immediate generator (I/S/B/J/U/SHAMT/ZIMM), extended to XLEN, with a sideband tag.
// Latency: one cycle from input acceptance to out_valid, with one result per cycle at full rate.
// Backpressure: in_ready drops while a held result is stalled by out_ready, or while flush is high.
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic [2:0]       imm_sel,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  imm_out,
    output logic [TAG_W-1:0] out_tag,
    output logic             illegal
);

    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("imm_gen_pipe: XLEN must be 32 or 64");
    end

    localparam logic [2:0] SEL_I     = 3'd0;
    localparam logic [2:0] SEL_S     = 3'd1;
    localparam logic [2:0] SEL_B     = 3'd2;
    localparam logic [2:0] SEL_J     = 3'd3;
    localparam logic [2:0] SEL_U     = 3'd4;
    localparam logic [2:0] SEL_SHAMT = 3'd5;
    localparam logic [2:0] SEL_ZIMM  = 3'd6;

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic [TAG_W-1:0] tag;
        logic             illegal;
    } out_t;

    out_t        out_q;
    out_t        out_nxt;
    logic [31:0] imm32;
    logic        sext;
    logic        accept;

    // Opcode bits do not contribute to any immediate.
    logic unused_opcode;
    assign unused_opcode = ^instr[6:0];

    // Each format is first built as a 32-bit value, then sign- or zero-extended once.
    always_comb begin
        imm32 = 32'd0;
        sext  = 1'b1;
        unique case (imm_sel)
            SEL_I: imm32 = {{20{instr[31]}}, instr[31:20]};
            SEL_S: imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            SEL_B: imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            SEL_J: imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            SEL_U: imm32 = {instr[31:12], 12'd0};
            SEL_SHAMT: begin
                sext  = 1'b0;
                imm32 = (XLEN == 32) ? {27'd0, instr[24:20]} : {26'd0, instr[25:20]};
            end
            SEL_ZIMM: begin
                sext  = 1'b0;
                imm32 = {27'd0, instr[19:15]};
            end
            default: begin
                sext  = 1'b0;
                imm32 = 32'd0;
            end
        endcase
    end

    always_comb begin
        out_nxt.imm     = sext ? XLEN'($signed(imm32)) : XLEN'(imm32);
        out_nxt.tag     = in_tag;
        out_nxt.illegal = (imm_sel == 3'd7);
    end

    assign in_ready = !flush && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_q     <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_q     <= out_nxt;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign imm_out = out_q.imm;
    assign out_tag = out_q.tag;
    assign illegal = out_q.illegal;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench: XLEN=32 and XLEN=64 instances share one stimulus stream.
module tb_imm_gen_pipe;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic [31:0] instr;
    logic [2:0]  imm_sel;
    logic [7:0]  in_tag;
    logic        out_ready;

    logic        in_ready32, out_valid32, illegal32;
    logic [31:0] imm32;
    logic [7:0]  tag32;
    logic        in_ready64, out_valid64, illegal64;
    logic [63:0] imm64;
    logic [7:0]  tag64;

    int n_chk  = 0;
    int n_fail = 0;

    imm_gen_pipe #(.XLEN(32), .TAG_W(8)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready32),
        .instr(instr), .imm_sel(imm_sel), .in_tag(in_tag),
        .out_valid(out_valid32), .out_ready(out_ready),
        .imm_out(imm32), .out_tag(tag32), .illegal(illegal32)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(8)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready64),
        .instr(instr), .imm_sel(imm_sel), .in_tag(in_tag),
        .out_valid(out_valid64), .out_ready(out_ready),
        .imm_out(imm64), .out_tag(tag64), .illegal(illegal64)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got hang required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] i, input logic [2:0] s, input logic [7:0] t);
        in_valid = v;
        instr    = i;
        imm_sel  = s;
        in_tag   = t;
    endtask

    typedef struct {
        logic [31:0] instr;
        logic [2:0]  sel;
        logic [31:0] e32;
        logic [63:0] e64;
    } vec_t;

    vec_t vecs[12];

    initial begin
        vecs[0]  = '{32'hFFF00093, 3'd0, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF};
        vecs[1]  = '{32'h7FF00093, 3'd0, 32'h000007FF, 64'h00000000000007FF};
        vecs[2]  = '{32'hFE512E23, 3'd1, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC};
        vecs[3]  = '{32'hFE000EE3, 3'd2, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC};
        vecs[4]  = '{32'hFFDFF06F, 3'd3, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC};
        vecs[5]  = '{32'h123450B7, 3'd4, 32'h12345000, 64'h0000000012345000};
        vecs[6]  = '{32'h800000B7, 3'd4, 32'h80000000, 64'hFFFFFFFF80000000};
        vecs[7]  = '{32'h00509093, 3'd5, 32'h00000005, 64'h0000000000000005};
        vecs[8]  = '{32'h03F09093, 3'd5, 32'h0000001F, 64'h000000000000003F};
        vecs[9]  = '{32'h000FD073, 3'd6, 32'h0000001F, 64'h000000000000001F};
        vecs[10] = '{32'h800F8073, 3'd6, 32'h0000001F, 64'h000000000000001F};
        vecs[11] = '{32'h00000000, 3'd0, 32'h00000000, 64'h0000000000000000};

        // Reset state
        rst_n     = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 32'd0, 3'd0, 8'd0);
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 64'(out_valid32), 64'd0);
        chk("rst_imm32", 64'(imm32), 64'd0);
        chk("rst_imm64", imm64, 64'd0);
        chk("rst_tag", 64'(tag32), 64'd0);
        chk("rst_illegal", 64'(illegal32), 64'd0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", 64'(in_ready32), 64'd1);

        // First transaction after reset
        @(negedge clk);
        drive(1'b1, 32'hFFF00093, 3'd0, 8'h11);
        @(negedge clk);
        chk("first_out_valid", 64'(out_valid32), 64'd1);
        chk("first_imm32", 64'(imm32), 64'hFFFFFFFF);
        chk("first_tag", 64'(tag32), 64'h11);
        chk("first_illegal", 64'(illegal32), 64'd0);

        // Back-to-back formats, one result per cycle
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, vecs[i].instr, vecs[i].sel, 8'(8'h20 + i));
            @(negedge clk);
            chk($sformatf("vec%0d_valid", i), 64'(out_valid32), 64'd1);
            chk($sformatf("vec%0d_in_ready", i), 64'(in_ready32), 64'd1);
            chk($sformatf("vec%0d_imm32", i), 64'(imm32), 64'(vecs[i].e32));
            chk($sformatf("vec%0d_imm64", i), imm64, vecs[i].e64);
            chk($sformatf("vec%0d_tag32", i), 64'(tag32), 64'(8'h20 + i));
            chk($sformatf("vec%0d_tag64", i), 64'(tag64), 64'(8'h20 + i));
            chk($sformatf("vec%0d_illegal", i), 64'({illegal32, illegal64}), 64'd0);
        end

        // Backpressure: held output, no acceptance, then release
        drive(1'b1, 32'h123450B7, 3'd4, 8'h40);
        @(negedge clk);
        chk("bp_first_imm", 64'(imm32), 64'h12345000);
        out_ready = 1'b0;
        drive(1'b1, 32'h7FF00093, 3'd0, 8'h41);
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("bp%0d_in_ready", c), 64'(in_ready32), 64'd0);
            @(negedge clk);
            chk($sformatf("bp%0d_valid", c), 64'(out_valid32), 64'd1);
            chk($sformatf("bp%0d_imm", c), 64'(imm32), 64'h12345000);
            chk($sformatf("bp%0d_tag", c), 64'(tag32), 64'h40);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", 64'(in_ready32), 64'd1);
        @(negedge clk);
        chk("bp_next_valid", 64'(out_valid32), 64'd1);
        chk("bp_next_imm", 64'(imm32), 64'h000007FF);
        chk("bp_next_tag", 64'(tag32), 64'h41);
        drive(1'b0, 32'd0, 3'd0, 8'd0);
        @(negedge clk);
        chk("bp_no_dup_valid", 64'(out_valid32), 64'd0);

        // Flush while stalled, with a same-cycle input
        out_ready = 1'b0;
        drive(1'b1, 32'h123450B7, 3'd4, 8'h50);
        @(negedge clk);
        chk("fl_pre_valid", 64'(out_valid32), 64'd1);
        flush = 1'b1;
        drive(1'b1, 32'hFFF00093, 3'd0, 8'h51);
        #1;
        chk("fl_in_ready", 64'(in_ready32), 64'd0);
        @(negedge clk);
        chk("fl_valid", 64'({out_valid32, out_valid64}), 64'd0);
        flush     = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 32'd0, 3'd0, 8'd0);
        @(negedge clk);
        chk("fl_not_captured", 64'(out_valid32), 64'd0);

        // Reserved selector, then async reset mid-stall
        drive(1'b1, 32'hFFFFFFFF, 3'd7, 8'h60);
        @(negedge clk);
        chk("rsv_valid", 64'(out_valid32), 64'd1);
        chk("rsv_illegal32", 64'(illegal32), 64'd1);
        chk("rsv_illegal64", 64'(illegal64), 64'd1);
        chk("rsv_imm32", 64'(imm32), 64'd0);
        chk("rsv_imm64", imm64, 64'd0);
        chk("rsv_tag", 64'(tag32), 64'h60);
        out_ready = 1'b0;
        drive(1'b0, 32'd0, 3'd0, 8'd0);
        @(posedge clk);
        #2;
        chk("arst_pre_valid", 64'(out_valid32), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 64'({out_valid32, out_valid64}), 64'd0);
        chk("arst_illegal", 64'(illegal32), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
Parametrised, pipelined immediate generator for the RISC-V decode stage. It covers every RV32/RV64 base immediate format: I, S, B, J, U, shift-amount and CSR zimm. The result is sign- or zero-extended to XLEN and registered behind a valid/ready handshake, with an optional sideband tag carried alongside. It sits between instruction fetch/decode and the execute-stage operand mux, with flush support for branch redirects.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64; the immediate is extended to XLEN.
TAG_W, 8, width of the opaque sideband tag carried with each instruction (e.g. rd/ROB id); minimum 1.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
flush  in  1  synchronous kill of the held entry and of any same-cycle input.
in_valid  in  1  instr/imm_sel/in_tag are valid.
in_ready  out  1  block accepts input this cycle.
instr  in  32  raw instruction word.
imm_sel  in  3  format: 0 I, 1 S, 2 B, 3 J, 4 U, 5 SHAMT, 6 ZIMM, 7 reserved.
in_tag  in  TAG_W  sideband tag.
out_valid  out  1  imm_out/out_tag/illegal are valid.
out_ready  in  1  consumer accepts output.
imm_out  out  XLEN  extended immediate.
out_tag  out  TAG_W  tag captured with the instruction.
illegal  out  1  imm_sel was 7 (reserved).

Behaviour:
- Reset (rst_n low, async): out_valid=0, imm_out=0, out_tag=0, illegal=0. After rst_n deasserts, in_ready=1 once flush is low.
- Single output register stage. Latency is exactly 1 cycle from input acceptance to out_valid.
- in_ready = !flush && (!out_valid || out_ready), combinational. Full throughput is one instruction per cycle while out_ready is held high.
- Accept: in_valid && in_ready at a rising edge. The register loads the computed imm, in_tag and illegal; out_valid is set to 1.
- Drain without refill: out_valid && out_ready && !accept. out_valid goes to 0 and data is held (don't-care).
- Stall: out_valid && !out_ready. imm_out, out_tag and illegal are held stable; no input is accepted.
- Flush: at the edge with flush=1, out_valid goes to 0 whatever out_ready/in_valid are. Same-cycle input is dropped (in_ready=0).
- Reset mid-stall: the entry is discarded immediately and out_valid=0 asynchronously.
- Immediate formats, with s = instr[31] replicated to XLEN:
  - I: {s, instr[31:20]}.
  - S: {s, instr[31:25], instr[11:7]}.
  - B: {s, instr[7], instr[30:25], instr[11:8], 0}.
  - J: {s, instr[19:12], instr[20], instr[30:21], 0}.
  - U: {s (XLEN>32 only), instr[31:12], 12'b0}.
  - SHAMT: zero-extended instr[24:20] when XLEN=32; instr[25:20] when XLEN=64.
  - ZIMM: zero-extended instr[19:15].
  - 7: imm_out=0 and illegal=1. The entry still handshakes normally.
- imm_out is a pure function of the captured instr/imm_sel; there is no state other than the output register and out_valid.
- XLEN values other than 32 or 64 are a configuration error, caught by an elaboration-time check.

Test Plan:
- Reset, XLEN=32: hold rst_n=0 → out_valid=0, imm_out=0. Release; in_valid=1, instr=0xFFF00093, sel=0, tag=0x11 → next cycle out_valid=1, imm_out=0xFFFFFFFF, out_tag=0x11, illegal=0.
- Formats, XLEN=32, back-to-back with out_ready=1 and one result per cycle:
  - S, 0xFE512E23 → 0xFFFFFFFC.
  - B, 0xFE000EE3 → 0xFFFFFFFC.
  - J, 0xFFDFF06F → 0xFFFFFFFC.
  - U, 0x123450B7 → 0x12345000.
  - SHAMT, 0x00509093 → 0x00000005.
- XLEN=64: I with 0xFFF00093 → 0xFFFFFFFFFFFFFFFF. U with 0x800000B7 → 0xFFFFFFFF80000000. SHAMT with 0x03F09093 → 0x3F.
- Backpressure: accept 0x123450B7/U, then drop out_ready=0 for 3 cycles with in_valid=1 → in_ready=0 and imm_out held at 0x12345000. Raise out_ready → the next instruction appears on the following cycle and none is lost or duplicated.
- Flush: out_valid=1 with out_ready=0; assert flush with in_valid=1 → next cycle out_valid=0 and the input was not captured (in_ready=0 during flush).
- Reserved and async reset: sel=7 → illegal=1, imm_out=0, out_valid=1. Then assert rst_n=0 mid-cycle while out_ready=0 → out_valid drops before the next clock edge.
